// File: rtl/trace_serializer.sv
// trace_serializer: accepts one TRB_WIDTH-bit trace word and emits it
// LSB first as TRB_WIDTH/n slices of n lanes, where n is sampled when the
// word is accepted. A new word can be accepted on the same edge as the
// last slice is consumed, so there is no bubble between words.
module trace_serializer #(
  parameter int unsigned TRB_WIDTH      = 32,
  parameter int unsigned TRB_MAX_TRACES = 8,
  parameter int unsigned LANE_BITS      = 2
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic [TRB_WIDTH-1:0]      DATA_I,
  input  logic                      DATA_VALID_I,
  output logic                      DATA_READY_O,
  input  logic                      TRIG_I,
  input  logic [LANE_BITS-1:0]      NUM_TRACES_I,
  output logic [TRB_MAX_TRACES-1:0] TRACE_O,
  output logic                      TRACE_VALID_O,
  input  logic                      TRACE_READY_I,
  output logic                      TRIG_O
);

  localparam int unsigned KW    = $clog2(TRB_WIDTH);
  localparam int unsigned MAXLG = $clog2(TRB_MAX_TRACES);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [KW-1:0]             k_q, k_d;
  logic [KW-1:0]             lg_q, lg_d;
  logic [TRB_WIDTH-1:0]      word_q, word_d;
  logic                      trig_q, trig_d;

  logic [KW-1:0]             lg_in;
  logic [KW:0]               slices;
  logic [KW-1:0]             shamt;
  logic                      last;
  logic                      valid;
  logic                      ready;
  logic                      accept;
  logic [TRB_MAX_TRACES-1:0] slice;

  // Clamp the requested lane exponent to the number of physical lanes.
  always_comb begin
    if (32'(NUM_TRACES_I) > MAXLG) lg_in = KW'(MAXLG);
    else                           lg_in = KW'(NUM_TRACES_I);
  end

  // Slice selection for the held word: lanes at or above n read as zero.
  always_comb begin
    slices = (KW+1)'(TRB_WIDTH) >> lg_q;
    last   = ({1'b0, k_q} == (slices - 1'b1));
    shamt  = k_q << lg_q;
    for (int unsigned j = 0; j < TRB_MAX_TRACES; j++) begin
      slice[j] = 1'b0;
      if (j < (32'd1 << lg_q)) slice[j] = word_q[shamt + KW'(j)];
    end
  end

  // Handshake and output gating; reset forces both handshakes low.
  always_comb begin
    valid         = (state_q == SHIFT) && !RST_I;
    ready         = !RST_I && ((state_q == IDLE) || (last && TRACE_READY_I));
    accept        = DATA_VALID_I && ready;
    DATA_READY_O  = ready;
    TRACE_VALID_O = valid;
    TRACE_O       = valid ? slice : '0;
    TRIG_O        = valid && trig_q;
  end

  // Next-state: acceptance loads a fresh word, otherwise advance on consume.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    lg_d    = lg_q;
    word_d  = word_q;
    trig_d  = trig_q;
    if (accept) begin
      state_d = SHIFT;
      k_d     = '0;
      lg_d    = lg_in;
      word_d  = DATA_I;
      trig_d  = TRIG_I;
    end else if ((state_q == SHIFT) && TRACE_READY_I) begin
      if (last) begin
        state_d = IDLE;
        k_d     = '0;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      k_q     <= '0;
      lg_q    <= '0;
      word_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lg_q    <= lg_d;
      word_q  <= word_d;
      trig_q  <= trig_d;
    end
  end

endmodule

// File: tb/tb_trace_serializer.sv
// Scoreboard bench for trace_serializer: tests push expected {trig, slice}
// pairs, a monitor pops and compares whenever a slice is presented.
module tb_trace_serializer;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [31:0] DATA_I = '0;
  logic        DATA_VALID_I = 1'b0;
  logic        DATA_READY_O;
  logic        TRIG_I = 1'b0;
  logic [2:0]  NUM_TRACES_I = '0;
  logic [7:0]  TRACE_O;
  logic        TRACE_VALID_O;
  logic        TRACE_READY_I = 1'b1;
  logic        TRIG_O;

  int total = 0;
  int bad   = 0;
  logic [8:0] expq[$];

  trace_serializer #(.TRB_WIDTH(32), .TRB_MAX_TRACES(8), .LANE_BITS(3)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DATA_I(DATA_I), .DATA_VALID_I(DATA_VALID_I),
    .DATA_READY_O(DATA_READY_O), .TRIG_I(TRIG_I), .NUM_TRACES_I(NUM_TRACES_I),
    .TRACE_O(TRACE_O), .TRACE_VALID_O(TRACE_VALID_O),
    .TRACE_READY_I(TRACE_READY_I), .TRIG_O(TRIG_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference slicing: n = 2**min(nt,3), slice k = bits [k*n +: n].
  task automatic push_model(input logic [31:0] d, input logic t, input logic [2:0] nt);
    int unsigned lg, n;
    logic [7:0] s;
    lg = (nt > 3) ? 3 : int'(nt);
    n  = 1 << lg;
    for (int unsigned k = 0; k < 32 / n; k++) begin
      s = '0;
      for (int unsigned j = 0; j < n; j++) s[j] = d[k*n + j];
      expq.push_back({t, s});
    end
  endtask

  task automatic push_one(input logic t, input logic [7:0] s);
    expq.push_back({t, s});
  endtask

  // Present a word until accepted; returns at the negedge after acceptance.
  task automatic send(input logic [31:0] d, input logic t, input logic [2:0] nt);
    bit got;
    got = 1'b0;
    DATA_I = d; TRIG_I = t; NUM_TRACES_I = nt; DATA_VALID_I = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      #1 got = DATA_READY_O;
      @(posedge CLK_I);
      if (!got) @(negedge CLK_I);
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: word 0x%0h not accepted, required acceptance", d);
    end else begin
      @(negedge CLK_I);
    end
    DATA_VALID_I = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge CLK_I);
      #3 done = (expq.size() == 0) && !TRACE_VALID_O;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d slices pending, required 0", expq.size());
      expq.delete();
    end
  endtask

  // Monitor: compare every presented slice; a stalled slice is compared
  // against the same expected entry until it is consumed.
  always begin
    @(negedge CLK_I);
    #2;
    if (TRACE_VALID_O) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_slice: got trig=%0b trace=0x%0h, required no slice", TRIG_O, TRACE_O);
      end else begin
        if ({TRIG_O, TRACE_O} !== expq[0]) begin
          bad++;
          $display("FAIL slice: got trig=%0b trace=0x%0h expected trig=%0b trace=0x%0h at %0t",
                   TRIG_O, TRACE_O, expq[0][8], expq[0][7:0], $time);
        end
        if (TRACE_READY_I) void'(expq.pop_front());
      end
    end else begin
      total++;
      if (TRACE_O !== 8'h00 || TRIG_O !== 1'b0) begin
        bad++;
        $display("FAIL idle_outputs: got trig=%0b trace=0x%0h, required 0/0x0", TRIG_O, TRACE_O);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge CLK_I);
    #1 check("rst_ready", 32'(DATA_READY_O), 0);
    check("rst_valid", 32'(TRACE_VALID_O), 0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    #1 check("idle_ready", 32'(DATA_READY_O), 1);
    check("idle_valid", 32'(TRACE_VALID_O), 0);
    @(negedge CLK_I);

    // Four words back to back at n=8: 16 slices with no gap
    for (int w = 0; w < 4; w++) push_model(32'(w), 1'b0, 3'd3);
    send(32'h0, 1'b0, 3'd3);
    fork
      begin
        send(32'h1, 1'b0, 3'd3);
        send(32'h2, 1'b0, 3'd3);
        send(32'h3, 1'b0, 3'd3);
      end
      begin
        for (int i = 0; i < 16; i++) begin
          #1 check("no_bubble", 32'(TRACE_VALID_O), 1);
          @(negedge CLK_I);
        end
      end
    join
    drain();

    // One lane, trigger held across all 32 slices, then back to idle
    push_model(32'hA5A5A5A5, 1'b1, 3'd0);
    send(32'hA5A5A5A5, 1'b1, 3'd0);
    drain();
    #1 check("post_word_ready", 32'(DATA_READY_O), 1);
    check("post_word_valid", 32'(TRACE_VALID_O), 0);

    // Four lanes with downstream stalls on slices 2 and 5
    for (int s = 8; s >= 1; s--) push_one(1'b0, 8'(s));
    send(32'h12345678, 1'b0, 3'd2);
    @(negedge CLK_I);
    @(negedge CLK_I);
    TRACE_READY_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    TRACE_READY_I = 1'b1;
    repeat (3) @(negedge CLK_I);
    TRACE_READY_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    TRACE_READY_I = 1'b1;
    drain();

    // Over-range lane request clamps to 8 lanes
    push_one(1'b0, 8'hEF); push_one(1'b0, 8'hBE);
    push_one(1'b0, 8'hAD); push_one(1'b0, 8'hDE);
    send(32'hDEADBEEF, 1'b0, 3'd5);
    drain();

    // Reset during slice 1: word discarded, next word starts at slice 0
    push_one(1'b0, 8'h0D);
    send(32'hCAFEF00D, 1'b0, 3'd3);
    @(negedge CLK_I);
    RST_I = 1'b1;
    #1 check("midrst_ready", 32'(DATA_READY_O), 0);
    check("midrst_valid", 32'(TRACE_VALID_O), 0);
    @(negedge CLK_I);
    RST_I = 1'b0;
    #1 check("postrst_valid", 32'(TRACE_VALID_O), 0);
    check("postrst_trace", 32'(TRACE_O), 0);
    check("postrst_ready", 32'(DATA_READY_O), 1);
    @(negedge CLK_I);
    push_one(1'b1, 8'h44); push_one(1'b1, 8'h33);
    push_one(1'b1, 8'h22); push_one(1'b1, 8'h11);
    send(32'h11223344, 1'b1, 3'd3);
    drain();

    // Lane count changed mid-word only affects the following word
    push_model(32'h89ABCDEF, 1'b0, 3'd3);
    push_model(32'h00000006, 1'b1, 3'd0);
    send(32'h89ABCDEF, 1'b0, 3'd3);
    send(32'h00000006, 1'b1, 3'd0);
    drain();

    repeat (3) @(negedge CLK_I);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
